serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Digit-serial N-bit subtractor: computes diff = a - b - bin, D bits per cycle, LSB first.
//  It is the inverse datapath to our combinational n_adder.
//  Sits behind a valid/ready request port and a valid/ready result port.
//  Used where area matters more than latency: small shared ALU slices, checksum undo paths.
// PARAMETERS
//  N  4  operand/result width in bits (N >= 1)
//  D  1  bits processed per cycle; N % D == 0 required (elaboration $error otherwise)
// PORTS
//  clk        in   1  rising-edge clock (single clock domain)
//  rst_n      in   1  synchronous reset, active-low
//  in_valid   in   1  request valid
//  in_ready   out  1  block can accept a request
//  a          in   N  minuend (unsigned)
//  b          in   N  subtrahend (unsigned)
//  bin        in   1  borrow-in
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  diff       out  N  (a - b - bin) mod 2^N
//  bout       out  1  borrow-out; 1 iff a < b + bin (unsigned compare)
//  ovf        out  1  only with SUB_OVF_EN; signed overflow flag
// BEHAVIOUR
//  - Reset (rst_n==0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0,
//    internal slice counter=0, borrow reg=0. Reset mid-operation aborts the operation; no result.
//  - FSM states:
//    - IDLE: in_ready=1. in_valid&&in_ready latches a, b and bin into the borrow reg; -> BUSY.
//    - BUSY: in_ready=0. At each edge, process slice i (bits i*D+D-1 : i*D):
//      {brw', d_slice} = a_slice - b_slice - brw, computed at width D+1.
//      d_slice is written into diff; brw is updated to brw'. i increments.
//      After slice N/D-1, bout=final brw; -> DONE.
//    - DONE: out_valid=1; diff and bout are held stable. in_ready=0.
//      out_valid&&out_ready -> IDLE, out_valid=0 next cycle.
//  - Latency: request accepted at edge k -> out_valid=1 after edge k+N/D.
//    Throughput is one op per N/D+2 cycles with out_ready tied high.
//  - No request is accepted in BUSY or DONE, even if out_ready is high in DONE.
//    The next request can be accepted in the cycle after the return to IDLE.
//  - in_valid while not ready is ignored. Inputs a, b and bin are sampled only at acceptance;
//    later changes to them have no effect.
//  - diff may show partial slices during BUSY; it is only valid while out_valid=1.
//  - Boundaries:
//    - a==b, bin=0 -> diff=0, bout=0.
//    - a=0, b=0, bin=1 -> diff=all ones, bout=1 (wrap).
//    - D==N -> single BUSY cycle.
// CONFIGURATION
//  SUB_OVF_EN defined:
//    - Adds port ovf. ovf=(a[N-1]!=b[N-1]) && (diff[N-1]!=a[N-1]), using the latched a and b.
//    - ovf is registered at the DONE entry, held with diff, and reset to 0.
//  SUB_OVF_EN undefined:
//    - Port ovf is absent; no overflow logic.
//    - All other behaviour is identical.
// TESTING  (N=4, D=1 unless noted)
//  1. a=5, b=3, bin=0 -> out_valid 4 cycles after accept; diff=2, bout=0.
//  2. a=3, b=5, bin=0 -> diff=E, bout=1.
//     a=0, b=0, bin=1 -> diff=F, bout=1.
//     a=7, b=7, bin=0 -> diff=0, bout=0.
//  3. a=C, b=5, bin=1, out_ready held low 3 cycles in DONE -> diff=6, bout=0 stable throughout.
//     in_ready stays 0 and a second in_valid is ignored. Release -> IDLE, in_ready=1.
//  4. Accept a=F, b=1; drive rst_n=0 on 2nd BUSY cycle -> out_valid never asserts.
//     After reset: diff=0, bout=0, in_ready=1.
//     Then a=9, b=2 completes with diff=7, bout=0.
//  5. SUB_OVF_EN: a=8, b=1 -> diff=7, ovf=1.
//     a=2, b=1 -> diff=1, ovf=0.
//     a=7, b=F -> diff=8, ovf=1.
//  6. N=8, D=2: a=0x10, b=0x01, bin=0 -> out_valid 4 cycles after accept; diff=0x0F, bout=0.
//     Scoreboard 1000 random ops vs (a-b-bin) with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Request/result port bundle for serial_subtractor.
// Optional overflow flag present only when SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned N = 4
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    // Requester / consumer side
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
`ifdef SUB_OVF_EN
        , input ovf
`endif
    );

    // Subtractor side
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
`ifdef SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, D bits per cycle, LSB first.
// Optional macro SUB_OVF_EN adds a registered signed-overflow flag (bus.ovf).
module serial_subtractor #(
    parameter int unsigned N = 4,
    parameter int unsigned D = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned SLICES = (D == 0) ? 1 : N / D;
    localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int unsigned DW     = D + 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    // Reject configurations the slice datapath cannot handle
    if ((N < 1) || (D < 1) || (D > N) || ((N % D) != 0)) begin : g_bad_cfg
        $error("serial_subtractor: N must be >= 1 and a multiple of D");
    end
    if ($bits(bus.a) != N) begin : g_bad_if
        $error("serial_subtractor: interface width does not match N");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  a_q, b_q, diff_q;
    logic [CW-1:0] cnt_q;
    logic          brw_q, bout_q;
    logic          in_ready_q, out_valid_q;
    logic          in_ready_n, out_valid_n;
    logic [D-1:0]  a_s, b_s, d_s;
    logic          brw_n;
    logic          accept, last_slice;
`ifdef SUB_OVF_EN
    logic          ovf_q;
`endif

    assign accept     = (state == IDLE) && bus.in_valid;
    assign last_slice = (cnt_q == LAST);

    // Current slice subtraction at width D+1; the top bit is the new borrow
    always_comb begin
        a_s = a_q[cnt_q * D +: D];
        b_s = b_q[cnt_q * D +: D];
        {brw_n, d_s} = {1'b0, a_s} - {1'b0, b_s} - DW'(brw_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_n = BUSY;
            BUSY:    if (last_slice)    state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default:                    state_n = IDLE;
        endcase
    end

    // Handshake outputs for the upcoming state, registered below
    always_comb begin
        in_ready_n  = 1'b0;
        out_valid_n = 1'b0;
        case (state_n)
            IDLE:    in_ready_n  = 1'b1;
            DONE:    out_valid_n = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, slice walk and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            brw_q       <= 1'b0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            if (accept) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                brw_q <= bus.bin;
                cnt_q <= '0;
            end
            if (state == BUSY) begin
                diff_q[cnt_q * D +: D] <= d_s;
                brw_q                  <= brw_n;
                cnt_q                  <= cnt_q + CW'(1);
                if (last_slice) begin
                    bout_q <= brw_n;
`ifdef SUB_OVF_EN
                    ovf_q  <= (a_q[N-1] != b_q[N-1]) && (d_s[D-1] != a_q[N-1]);
`endif
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
`ifdef SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: N=4/D=1 and N=8/D=2 instances, optional SUB_OVF_EN.
module tb_serial_subtractor;
    localparam int unsigned N4 = 4;
    localparam int unsigned D4 = 1;
    localparam int unsigned N8 = 8;
    localparam int unsigned D8 = 2;
    localparam int unsigned NOPS = 1000;

    logic clk = 1'b0;
    logic rst_n4, rst_n8;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.N(N4)) bus4 ();
    serial_subtractor_if #(.N(N8)) bus8 ();

    serial_subtractor #(.N(N4), .D(D4)) dut4 (.clk(clk), .rst_n(rst_n4), .bus(bus4));
    serial_subtractor #(.N(N8), .D(D8)) dut8 (.clk(clk), .rst_n(rst_n8), .bus(bus8));

    // Reference: integer subtraction, borrow = negative result, ovf = signed result out of range
    function automatic void ref_sub(input int n, input int a, input int b, input int bin,
                                    output int d, output logic bo, output logic ov);
        int t, sa, sb, r;
        t  = a - b - bin;
        d  = (t + (1 << n)) % (1 << n);
        bo = (t < 0);
        sa = (a >= (1 << (n - 1))) ? a - (1 << n) : a;
        sb = (b >= (1 << (n - 1))) ? b - (1 << n) : b;
        r  = sa - sb - bin;
        ov = (r > ((1 << (n - 1)) - 1)) || (r < -(1 << (n - 1)));
    endfunction

    // One complete transaction on the N=4 instance, checking latency and result
    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int   ed, cyc;
        logic eb, eo;
        ref_sub(4, int'(a), int'(b), int'(bin), ed, eb, eo);
        @(negedge clk);
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            errors++; $display("FAIL op4_in_ready got=%b exp=1", bus4.in_ready);
        end
        bus4.in_valid = 1'b1; bus4.a = a; bus4.b = b; bus4.bin = bin;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.bin = 1'($urandom);
        cyc = 0;
        while (bus4.out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        checks++;
        if (cyc != int'(N4 / D4)) begin
            errors++; $display("FAIL op4_latency got=%0d exp=%0d", cyc, N4 / D4);
        end
        checks++;
        if (bus4.diff !== 4'(ed) || bus4.bout !== eb) begin
            errors++;
            $display("FAIL op4_result a=%h b=%h bin=%b got=%h/%b exp=%h/%b",
                     a, b, bin, bus4.diff, bus4.bout, 4'(ed), eb);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (bus4.ovf !== eo) begin
            errors++; $display("FAIL op4_ovf a=%h b=%h got=%b exp=%b", a, b, bus4.ovf, eo);
        end
`endif
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL op4_release got=%b/%b exp=0/1", bus4.out_valid, bus4.in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n4 = 1'b0; rst_n8 = 1'b0;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.diff !== 4'h0 ||
            bus4.bout !== 1'b0) begin
            errors++;
            $display("FAIL reset4 got rdy=%b vld=%b diff=%h bout=%b exp 1/0/0/0",
                     bus4.in_ready, bus4.out_valid, bus4.diff, bus4.bout);
        end
        checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.diff !== 8'h00 ||
            bus8.bout !== 1'b0) begin
            errors++;
            $display("FAIL reset8 got rdy=%b vld=%b diff=%h bout=%b exp 1/0/0/0",
                     bus8.in_ready, bus8.out_valid, bus8.diff, bus8.bout);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (bus4.ovf !== 1'b0 || bus8.ovf !== 1'b0) begin
            errors++; $display("FAIL reset_ovf got=%b/%b exp=0/0", bus4.ovf, bus8.ovf);
        end
`endif
        rst_n4 = 1'b1; rst_n8 = 1'b1;
    endtask

    task automatic test_basic();
        do_op4(4'h5, 4'h3, 1'b0);
        do_op4(4'h3, 4'h5, 1'b0);
        do_op4(4'h0, 4'h0, 1'b1);
        do_op4(4'h7, 4'h7, 1'b0);
        for (int i = 0; i < 30; i++)
            do_op4(4'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        bus4.in_valid = 1'b1; bus4.a = 4'hC; bus4.b = 4'h5; bus4.bin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        cyc = 0;
        while (bus4.out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.diff !== 4'h6 || bus4.bout !== 1'b0 ||
                bus4.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got vld=%b diff=%h bout=%b rdy=%b exp 1/6/0/0",
                         i, bus4.out_valid, bus4.diff, bus4.bout, bus4.in_ready);
            end
            if (i == 1) begin
                bus4.in_valid = 1'b1; bus4.a = 4'h1; bus4.b = 4'h1; bus4.bin = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b0;
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.diff !== 4'h6) begin
            errors++;
            $display("FAIL hold_release got rdy=%b vld=%b diff=%h exp 1/0/6",
                     bus4.in_ready, bus4.out_valid, bus4.diff);
        end
        cyc = 0;
        repeat (N4 / D4 + 3) begin
            @(posedge clk); @(negedge clk);
            if (bus4.out_valid !== 1'b0) cyc++;
        end
        checks++;
        if (cyc != 0) begin
            errors++; $display("FAIL ignored_request got=%0d valid cycles exp=0", cyc);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        @(negedge clk);
        bus4.in_valid = 1'b1; bus4.a = 4'hF; bus4.b = 4'h1; bus4.bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus4.diff !== 4'h0 || bus4.bout !== 1'b0 || bus4.in_ready !== 1'b1 ||
            bus4.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset got diff=%h bout=%b rdy=%b vld=%b exp 0/0/1/0",
                     bus4.diff, bus4.bout, bus4.in_ready, bus4.out_valid);
        end
        rst_n4 = 1'b1;
        cyc = 0;
        repeat (N4 / D4 + 3) begin
            @(posedge clk); @(negedge clk);
            if (bus4.out_valid !== 1'b0) cyc++;
        end
        checks++;
        if (cyc != 0) begin
            errors++; $display("FAIL abort_no_result got=%0d valid cycles exp=0", cyc);
        end
        do_op4(4'h9, 4'h2, 1'b0);
    endtask

    task automatic test_ovf();
`ifdef SUB_OVF_EN
        do_op4(4'h8, 4'h1, 1'b0);
        do_op4(4'h2, 4'h1, 1'b0);
        do_op4(4'h7, 4'hF, 1'b0);
        do_op4(4'h8, 4'h0, 1'b1);
        do_op4(4'h0, 4'h8, 1'b1);
`endif
    endtask

    task automatic test_wide();
        int   cyc, got, ed, w;
        logic eb, eo, acc, rdy;
        int   q_d[$];
        logic q_b[$];
        logic q_o[$];
        // Directed: 0x10 - 0x01
        @(negedge clk);
        bus8.in_valid = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        cyc = 0;
        while (bus8.out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        checks++;
        if (cyc != int'(N8 / D8) || bus8.diff !== 8'h0F || bus8.bout !== 1'b0) begin
            errors++;
            $display("FAIL wide_directed got lat=%0d diff=%h bout=%b exp lat=%0d diff=0f bout=0",
                     cyc, bus8.diff, bus8.bout, N8 / D8);
        end
        bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.out_ready = 1'b0;
        // Randomized scoreboard with gaps on both sides
        got = 0;
        fork
            begin
                for (int i = 0; i < int'(NOPS); i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    bus8.in_valid = 1'b1;
                    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
                    acc = 1'b0; w = 0;
                    while (!acc && w < 100) begin
                        acc = bus8.in_ready;
                        @(posedge clk);
                        if (!acc) @(negedge clk);
                        w++;
                    end
                    if (acc) begin
                        ref_sub(8, int'(bus8.a), int'(bus8.b), int'(bus8.bin), ed, eb, eo);
                        q_d.push_back(ed); q_b.push_back(eb); q_o.push_back(eo);
                    end
                    @(negedge clk);
                    bus8.in_valid = 1'b0;
                end
            end
            begin
                cyc = 0;
                while (got < int'(NOPS) && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    rdy = ($urandom_range(0, 3) != 0);
                    bus8.out_ready = rdy;
                    if (bus8.out_valid === 1'b1 && rdy) begin
                        checks++;
                        if (q_d.size() == 0) begin
                            errors++; $display("FAIL sb_unexpected got diff=%h exp none", bus8.diff);
                        end else begin
                            if (bus8.diff !== 8'(q_d[0]) || bus8.bout !== q_b[0]
`ifdef SUB_OVF_EN
                                || bus8.ovf !== q_o[0]
`endif
                               ) begin
                                errors++;
                                $display("FAIL sb_op%0d got diff=%h bout=%b exp diff=%h bout=%b",
                                         got, bus8.diff, bus8.bout, 8'(q_d[0]), q_b[0]);
                            end
                            void'(q_d.pop_front()); void'(q_b.pop_front()); void'(q_o.pop_front());
                        end
                        got++;
                    end
                end
                @(negedge clk);
                bus8.out_ready = 1'b0;
            end
        join
        checks++;
        if (got != int'(NOPS) || q_d.size() != 0) begin
            errors++;
            $display("FAIL sb_count got=%0d pending=%0d exp=%0d pending=0", got, q_d.size(), NOPS);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_abort();
        test_ovf();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
